seg_cla_adder: RTL and testbench

- Multi-beat, parametrised wide adder for the arithmetic datapath.
- Accepts NUM_CHUNKS operand chunks of CHUNK_W bits, least-significant first, over a valid/ready handshake.
- Adds each chunk with a carry-lookahead chunk adder and ripples the carry between beats through a register.
- Assembles the full TOTAL_W sum and presents it with carry-out on an output handshake.
- Generalised successor of the fixed 4×12-bit flag-driven adder: adds real sequencing, carry chaining and backpressure.

---
 rtl/seg_cla_pkg.sv | 14 +
 rtl/seg_cla_adder_cla_chunk.sv | 63 ++++++
 rtl/seg_cla_adder.sv | 102 ++++++++++
 tb/tb_seg_cla_adder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_cla_pkg.sv
// Shared types and defaults for the segmented carry-lookahead adder.
// Optional overflow output is enabled with SEG_CLA_OVF_EN.
package seg_cla_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_CHUNK_W    = 12;
  localparam int DEF_NUM_CHUNKS = 4;

endpackage

// File: rtl/seg_cla_adder_cla_chunk.sv
// Combinational CHUNK_W-bit carry-lookahead adder, 4-bit groups.
// c_msb (carry into the MSB) exists only with SEG_CLA_OVF_EN.
module cla_chunk #(
  parameter int CHUNK_W = 12
) (
  input  logic [CHUNK_W-1:0] x,
  input  logic [CHUNK_W-1:0] y,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout
`ifdef SEG_CLA_OVF_EN
  ,
  output logic               c_msb
`endif
);

  localparam int NG = (CHUNK_W + 3) / 4;
  localparam int PW = NG * 4;

  logic [PW:0] cv;

  // Group generate/propagate, then lookahead carries per group and bit.
  always_comb begin
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic [PW:0]   c;
    // Pad bits propagate so a partial top group still passes its carry.
    g = '0;
    p = '1;
    g[CHUNK_W-1:0] = x & y;
    p[CHUNK_W-1:0] = x ^ y;
    for (int k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    c = '0;
    for (int k = 0; k < NG; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[PW] = gc[NG];
    cv = c;
  end

  assign s    = x ^ y ^ cv[CHUNK_W-1:0];
  assign cout = cv[CHUNK_W];
`ifdef SEG_CLA_OVF_EN
  assign c_msb = cv[CHUNK_W-1];
`endif

endmodule

// File: rtl/seg_cla_adder.sv
// Multi-beat wide adder: one CLA chunk per beat, carry chained in a register.
// Optional ovf output is enabled with SEG_CLA_OVF_EN.
module seg_cla_adder
  import seg_cla_pkg::*;
#(
  parameter int CHUNK_W    = DEF_CHUNK_W,
  parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
  localparam int TOTAL_W   = CHUNK_W * NUM_CHUNKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ci,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_a,
  input  logic [CHUNK_W-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] sum,
  output logic               co,
`ifdef SEG_CLA_OVF_EN
  output logic               ovf,
`endif
  output logic               busy
);

  localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CHUNKS - 1);

  state_t        state;
  logic          carry;
  logic [IW-1:0] idx;
  logic [CHUNK_W-1:0] s;
  logic          c;
`ifdef SEG_CLA_OVF_EN
  logic          c_msb;
`endif

  cla_chunk #(
    .CHUNK_W(CHUNK_W)
  ) u_cla (
    .x    (in_a),
    .y    (in_b),
    .cin  (carry),
    .s    (s),
    .cout (c)
`ifdef SEG_CLA_OVF_EN
    ,
    .c_msb(c_msb)
`endif
  );

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Sequencer: accept start, accumulate one chunk per beat, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      co    <= 1'b0;
`ifdef SEG_CLA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            carry <= ci;
            idx   <= '0;
            sum   <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sum[idx*CHUNK_W +: CHUNK_W] <= s;
            carry <= c;
            if (idx == LAST) begin
              co    <= c;
`ifdef SEG_CLA_OVF_EN
              ovf   <= c ^ c_msb;
`endif
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_cla_adder.sv
// Scoreboard bench for seg_cla_adder: random and directed operations.
// Define SEG_CLA_OVF_EN to also check the ovf output.
module tb_seg_cla_adder;

  localparam int CW = 12;
  localparam int NC = 4;
  localparam int TW = CW * NC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ci = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_a = '0;
  logic [CW-1:0] in_b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [TW-1:0] sum;
  logic          co;
  logic          busy;
`ifdef SEG_CLA_OVF_EN
  logic          ovf;
`endif

  typedef struct {
    logic [TW-1:0] sum;
    logic          co;
    logic          ovf;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  seg_cla_adder #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ci       (ci),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .co       (co),
`ifdef SEG_CLA_OVF_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [TW-1:0] a, logic [TW-1:0] b,
                                 logic c);
    exp_t e;
    logic [TW:0] full;
    full  = {1'b0, a} + {1'b0, b} + (TW+1)'(c);
    e.sum = full[TW-1:0];
    e.co  = full[TW];
    e.ovf = (a[TW-1] == b[TW-1]) && (e.sum[TW-1] != a[TW-1]);
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Monitor: compare every accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum %0h expected none", sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_sum", 64'(sum), 64'(e.sum));
        chk("mon_co", 64'(co), 64'(e.co));
`ifdef SEG_CLA_OVF_EN
        chk("mon_ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
    end
  end

  task automatic run_op(logic [TW-1:0] a, logic [TW-1:0] b, logic c,
                        int gap_at, int gap_len, int hold, bit poke);
    exp_t e;
    int n;
    e = model(a, b, c);
    @(posedge clk); #1;
    start    = 1'b1;
    ci       = c;
    in_valid = 1'b1;
    in_a     = CW'($urandom);
    in_b     = CW'($urandom);
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          chk("in_ready_gap", 64'(in_ready), 64'd1);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_a = a[i*CW +: CW];
      in_b = b[i*CW +: CW];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      if (i == NC - 1) chk("out_valid_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("out_valid_lat", 64'(out_valid), 64'd1);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start = poke;
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_sum", 64'(sum), 64'(e.sum));
      chk("hold_co", 64'(co), 64'(e.co));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    start = poke;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_sum_kept", 64'(sum), 64'(e.sum));
    chk("idle_co_kept", 64'(co), 64'(e.co));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
`ifdef SEG_CLA_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_ignore_busy", 64'(busy), 64'd0);
    chk("idle_ignore_valid", 64'(out_valid), 64'd0);

    run_op(48'hFFF_FFF_FFF_FFF, 48'h000_000_000_001, 1'b0, -1, 0, 0, 0);
    run_op(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b1, -1, 0, 0, 0);
    run_op(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b1, 2, 3, 0, 0);
    run_op(48'h123_456_789_ABC, 48'h111_111_111_111, 1'b1, -1, 0, 5, 1);

    @(posedge clk); #1;
    start = 1'b1;
    ci    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_a     = 12'hFFF;
    in_b     = 12'hFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    run_op(48'h000_000_000_005, 48'h000_000_000_003, 1'b0, -1, 0, 0, 0);

`ifdef SEG_CLA_OVF_EN
    run_op(48'h7FF_FFF_FFF_FFF, 48'h000_000_000_001, 1'b0, -1, 0, 0, 0);
    run_op(48'hFFF_FFF_FFF_FFF, 48'h000_000_000_001, 1'b0, -1, 0, 0, 0);
`endif

    for (int r = 0; r < 25; r++) begin
      logic [TW-1:0] ra;
      logic [TW-1:0] rb;
      ra = {16'($urandom), $urandom};
      rb = {16'($urandom), $urandom};
      if (r % 5 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, NC)),
             int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
